// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes, flag bit positions and write-back latency bounds
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int WB_LAT_MIN = 1;
   localparam int WB_LAT_MAX = 4;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluation against the flag register
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // 1111 is treated like AL through the default arm
   always_comb begin
      CondEx = 1'b1;
      case (Cond)
         EQ:      CondEx = z;
         NE:      CondEx = ~z;
         CS:      CondEx = c;
         CC:      CondEx = ~c;
         MI:      CondEx = n;
         PL:      CondEx = ~n;
         VS:      CondEx = v;
         VC:      CondEx = ~v;
         HI:      CondEx = c & ~z;
         LS:      CondEx = ~c | z;
         GE:      CondEx = ~(n ^ v);
         LT:      CondEx = n ^ v;
         GT:      CondEx = ~z & ~(n ^ v);
         LE:      CondEx = z | (n ^ v);
         default: CondEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_logic_pipe.sv
// rtl/cond_logic_pipe.sv - conditional-execution control with flag shadow, M/W write pipe and squash counter
module cond_logic_pipe
   import cond_pkg::*;
#(
   parameter int WB_LAT = 1,
   parameter int CNT_W  = 16
)
(
   input  logic             CLK,
   input  logic             reset,
   input  logic             Valid,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic [1:0]       FlagW,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic             FlagSave,
   input  logic             FlagRestore,
   input  logic             CntClr,
   output logic             PCSrc,
   output logic             RegWrite_M,
   output logic             MemWrite_M,
   output logic             RegWrite_W,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SquashCnt
);

   localparam int LAT = (WB_LAT < WB_LAT_MIN) ? WB_LAT_MIN :
                        (WB_LAT > WB_LAT_MAX) ? WB_LAT_MAX : WB_LAT;

   logic           condex;
   logic           fire;
   logic           pass;
   logic [3:0]     shadow;
   logic [3:0]     flags_nx;
   logic [LAT-1:0] wline;

   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (condex)
   );

   assign fire  = Valid & ~Stall & ~Flush;
   assign pass  = fire & condex;
   // gated by reset so a branch in flight at reset assertion never reaches fetch
   assign PCSrc = reset & pass & PCS;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         RegWrite_M <= 1'b0;
         MemWrite_M <= 1'b0;
         wline      <= '0;
      end else if (!Stall) begin
         RegWrite_M <= pass & RegW & ~NoWrite;
         MemWrite_M <= pass & MemW;
         wline[0]   <= RegWrite_M;
         for (int i = 1; i < LAT; i++) begin
            wline[i] <= wline[i-1];
         end
      end
   end

   assign RegWrite_W = wline[LAT-1];

   // restore wins over a same-cycle ALU flag write
   always_comb begin
      flags_nx = Flags;
      if (pass && FlagW[1]) flags_nx[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
      if (pass && FlagW[0]) flags_nx[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
      if (FlagRestore)      flags_nx = shadow;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         Flags  <= 4'b0000;
         shadow <= 4'b0000;
      end else if (!Stall) begin
         Flags <= flags_nx;
         if (FlagSave) shadow <= Flags;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         SquashCnt <= '0;
      end else if (CntClr) begin
         SquashCnt <= '0;
      end else if (fire && !condex && !(&SquashCnt)) begin
         SquashCnt <= SquashCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cond_logic_pipe.sv
// tb/tb_cond_logic_pipe.sv - self-checking bench for cond_logic_pipe with a behavioural reference model
module tb_cond_logic_pipe;

   localparam int LAT_A = 3;
   localparam int LAT_B = 1;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       reset, Valid, Stall, Flush, PCS, RegW, MemW, NoWrite;
   logic       FlagSave, FlagRestore, CntClr;
   logic [1:0] FlagW;
   logic [3:0] Cond, ALUFlags;

   logic        pcsrc_a, rwm_a, mwm_a, rww_a;
   logic [3:0]  flags_a;
   logic [15:0] cnt_a;
   logic        pcsrc_b, rwm_b, mwm_b, rww_b;
   logic [3:0]  flags_b;
   logic [3:0]  cnt_b;

   int compared   = 0;
   int mismatched = 0;

   logic [3:0] m_flags, m_shadow;
   logic       m_rwm, m_mwm;
   int         m_cnt16, m_cnt4;
   logic       hist[$];

   cond_logic_pipe #(.WB_LAT(LAT_A), .CNT_W(16)) dut_a (
      .CLK(CLK), .reset(reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagSave(FlagSave), .FlagRestore(FlagRestore),
      .CntClr(CntClr), .PCSrc(pcsrc_a), .RegWrite_M(rwm_a), .MemWrite_M(mwm_a),
      .RegWrite_W(rww_a), .Flags(flags_a), .SquashCnt(cnt_a)
   );

   cond_logic_pipe #(.WB_LAT(LAT_B), .CNT_W(4)) dut_b (
      .CLK(CLK), .reset(reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagSave(FlagSave), .FlagRestore(FlagRestore),
      .CntClr(CntClr), .PCSrc(pcsrc_b), .RegWrite_M(rwm_b), .MemWrite_M(mwm_b),
      .RegWrite_W(rww_b), .Flags(flags_b), .SquashCnt(cnt_b)
   );

   // ARM condition truth table from the individual N, Z, C, V flags
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic exp_pc();
      return reset && Valid && !Stall && !Flush && PCS && cond_ok(Cond, m_flags);
   endfunction

   function automatic logic exp_w(input int lat);
      return hist[hist.size() - lat];
   endfunction

   task automatic idle();
      Valid = 0; Stall = 0; Flush = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
      FlagW = 2'b00; Cond = 4'b1110; ALUFlags = 4'b0000;
      FlagSave = 0; FlagRestore = 0; CntClr = 0;
   endtask

   task automatic model_clear();
      m_flags = 4'b0; m_shadow = 4'b0; m_rwm = 0; m_mwm = 0; m_cnt16 = 0; m_cnt4 = 0;
      hist = {};
      for (int i = 0; i < 4; i++) hist.push_back(1'b0);
   endtask

   task automatic do_reset();
      idle();
      reset = 0;
      model_clear();
      #2;
      reset = 1;
      #1;
   endtask

   // advance one clock edge and move the model forward with the same inputs
   task automatic tick();
      logic ce, fire;
      logic [3:0] nf, ns;
      logic nr, nm;
      int c16, c4;
      ce = cond_ok(Cond, m_flags);
      fire = Valid && !Stall && !Flush;
      nf = m_flags; ns = m_shadow; nr = m_rwm; nm = m_mwm;
      c16 = m_cnt16; c4 = m_cnt4;
      if (!Stall) begin
         nr = fire && ce && RegW && !NoWrite;
         nm = fire && ce && MemW;
         if (fire && ce && FlagW[1]) nf[3:2] = ALUFlags[3:2];
         if (fire && ce && FlagW[0]) nf[1:0] = ALUFlags[1:0];
         if (FlagRestore) nf = m_shadow;
         if (FlagSave) ns = m_flags;
      end
      if (CntClr) begin
         c16 = 0; c4 = 0;
      end else if (fire && !ce) begin
         if (c16 < 65535) c16++;
         if (c4 < 15) c4++;
      end
      @(posedge CLK);
      #1;
      if (!Stall) begin
         hist.push_back(m_rwm);
         if (hist.size() > 8) void'(hist.pop_front());
      end
      m_flags = nf; m_shadow = ns; m_rwm = nr; m_mwm = nm; m_cnt16 = c16; m_cnt4 = c4;
   endtask

   task automatic test_reset();
      logic [27:0] obs;
      do_reset();
      Valid = 1; Cond = 4'b1110; RegW = 1; MemW = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
      tick();
      Cond = 4'b0001;
      tick();
      Cond = 4'b1110; PCS = 1;
      reset = 0;
      #1;
      obs = {pcsrc_a, rwm_a, mwm_a, rww_a, flags_a, cnt_a, pcsrc_b, rwm_b, mwm_b, rww_b};
      compared++;
      if (obs !== 28'h0 || flags_b !== 4'h0 || cnt_b !== 4'h0) begin
         mismatched++;
         $display("FAIL reset_async: got %h flags_b=%h cnt_b=%h, want all zero", obs, flags_b, cnt_b);
      end
      model_clear();
      idle();
      #2;
      reset = 1;
      #1;
   endtask

   task automatic test_squash_eq();
      do_reset();
      Valid = 1; Cond = 4'b0000; RegW = 1; PCS = 1;
      #1;
      compared++;
      if (pcsrc_a !== 1'b0) begin
         mismatched++;
         $display("FAIL eq_pcsrc: got %b want 0", pcsrc_a);
      end
      tick();
      compared++;
      if (rwm_a !== 1'b0 || cnt_a !== 16'd1 || cnt_b !== 4'd1) begin
         mismatched++;
         $display("FAIL eq_squash: rwm=%b cnt_a=%0d cnt_b=%0d want 0/1/1", rwm_a, cnt_a, cnt_b);
      end
   endtask

   task automatic test_flag_forward();
      do_reset();
      Valid = 1; FlagW = 2'b11; ALUFlags = 4'b0100; Cond = 4'b1110;
      tick();
      compared++;
      if (flags_a !== 4'b0100) begin
         mismatched++;
         $display("FAIL fwd_flags: got %b want 0100", flags_a);
      end
      FlagW = 2'b00; Cond = 4'b0000; PCS = 1;
      #1;
      compared++;
      if (pcsrc_a !== 1'b1 || pcsrc_b !== 1'b1) begin
         mismatched++;
         $display("FAIL fwd_pcsrc: got %b/%b want 1/1", pcsrc_a, pcsrc_b);
      end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      Valid = 1; Cond = 4'b1110; RegW = 1;
      tick();
      compared++;
      if (rwm_a !== 1'b1) begin
         mismatched++;
         $display("FAIL stall_setup: rwm got %b want 1", rwm_a);
      end
      Stall = 1; RegW = 0; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         tick();
         compared++;
         if (rwm_a !== 1'b1 || flags_a !== 4'b0 || cnt_a !== 16'd0 || rww_a !== 1'b0 || rww_b !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_hold[%0d]: rwm=%b flags=%b cnt=%0d w=%b/%b want 1/0000/0/0/0",
                     k, rwm_a, flags_a, cnt_a, rww_a, rww_b);
         end
      end
      idle();
      for (int k = 1; k <= 4; k++) begin
         tick();
         compared++;
         if (rww_a !== (k == LAT_A) || rww_b !== (k == LAT_B)) begin
            mismatched++;
            $display("FAIL stall_wb[%0d]: w_a=%b w_b=%b want %b/%b", k, rww_a, rww_b, k == LAT_A, k == LAT_B);
         end
      end
   endtask

   task automatic test_save_restore();
      do_reset();
      Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001;
      tick();
      idle(); FlagSave = 1;
      tick();
      idle(); Valid = 1; FlagW = 2'b11; ALUFlags = 4'b0110;
      tick();
      compared++;
      if (flags_a !== 4'b0110) begin
         mismatched++;
         $display("FAIL sr_alu: got %b want 0110", flags_a);
      end
      FlagRestore = 1; ALUFlags = 4'b0110;
      tick();
      compared++;
      if (flags_a !== 4'b1001) begin
         mismatched++;
         $display("FAIL sr_restore: got %b want 1001", flags_a);
      end
      idle(); Valid = 1; FlagW = 2'b11; ALUFlags = 4'b0011;
      tick();
      idle(); FlagSave = 1; FlagRestore = 1;
      tick();
      compared++;
      if (flags_a !== 4'b1001) begin
         mismatched++;
         $display("FAIL sr_swap: got %b want 1001", flags_a);
      end
      idle(); FlagRestore = 1;
      tick();
      compared++;
      if (flags_a !== 4'b0011 || flags_b !== 4'b0011) begin
         mismatched++;
         $display("FAIL sr_swap_shadow: got %b/%b want 0011", flags_a, flags_b);
      end
      idle();
   endtask

   task automatic test_flush();
      Flush = 1; Valid = 1; Cond = 4'b1110; MemW = 1; RegW = 1; FlagW = 2'b11;
      ALUFlags = 4'b1100; PCS = 1;
      #1;
      compared++;
      if (pcsrc_a !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_pcsrc: got %b want 0", pcsrc_a);
      end
      tick();
      compared++;
      if (mwm_a !== 1'b0 || rwm_a !== 1'b0 || flags_a !== 4'b0011) begin
         mismatched++;
         $display("FAIL flush_block: mwm=%b rwm=%b flags=%b want 0/0/0011", mwm_a, rwm_a, flags_a);
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      Valid = 1; Cond = 4'b0000;
      for (int k = 0; k < 17; k++) tick();
      compared++;
      if (cnt_b !== 4'hF || cnt_a !== 16'd17) begin
         mismatched++;
         $display("FAIL sat_count: cnt_b=%h cnt_a=%0d want F/17", cnt_b, cnt_a);
      end
      CntClr = 1;
      tick();
      compared++;
      if (cnt_b !== 4'h0 || cnt_a !== 16'd0) begin
         mismatched++;
         $display("FAIL sat_clr: cnt_b=%h cnt_a=%0d want 0/0", cnt_b, cnt_a);
      end
      CntClr = 0;
      tick();
      Stall = 1; CntClr = 1;
      tick();
      compared++;
      if (cnt_a !== 16'd0 || cnt_b !== 4'h0) begin
         mismatched++;
         $display("FAIL sat_clr_stall: cnt_a=%0d cnt_b=%h want 0/0", cnt_a, cnt_b);
      end
      idle();
   endtask

   task automatic test_random();
      logic [47:0] obs, expv;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         Valid = ($urandom % 4) != 0;
         Stall = ($urandom % 5) == 0;
         Flush = ($urandom % 6) == 0;
         PCS = $urandom; RegW = $urandom; MemW = $urandom; NoWrite = ($urandom % 4) == 0;
         FlagW = 2'($urandom); Cond = 4'($urandom); ALUFlags = 4'($urandom);
         FlagSave = ($urandom % 8) == 0; FlagRestore = ($urandom % 8) == 0;
         CntClr = ($urandom % 40) == 0;
         #1;
         compared++;
         if (pcsrc_a !== exp_pc() || pcsrc_b !== exp_pc()) begin
            mismatched++;
            $display("FAIL rand_pcsrc[%0d]: got %b/%b want %b", k, pcsrc_a, pcsrc_b, exp_pc());
         end
         tick();
         obs  = {rwm_a, mwm_a, rww_a, flags_a, cnt_a, rwm_b, mwm_b, rww_b, flags_b, cnt_b, 13'h0};
         expv = {m_rwm, m_mwm, exp_w(LAT_A), m_flags, 16'(m_cnt16),
                 m_rwm, m_mwm, exp_w(LAT_B), m_flags, 4'(m_cnt4), 13'h0};
         compared++;
         if (obs !== expv) begin
            mismatched++;
            $display("FAIL rand_state[%0d]: got %h want %h", k, obs, expv);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 0;
      model_clear();
      #12;
      reset = 1;
      test_reset();
      test_squash_eq();
      test_flag_forward();
      test_stall();
      test_save_restore();
      test_flush();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
